// File: rtl/misao_pkg.sv
// Shared types for the misao core memory path: byte type, fetch-buffer FSM
// states and in-flight access kinds.
package misao_pkg;

    localparam int DEFAULT_ADDR_W = 15;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } fb_state_e;

    typedef enum logic {
        DEMAND   = 1'b0,
        PREFETCH = 1'b1
    } inflight_kind_e;

endpackage

// File: rtl/misao_fetch_fifo.sv
// Small tagged FIFO of {addr, data} prefetch entries with synchronous flush;
// exposes the head entry and the current occupancy.
module misao_fetch_fifo
    import misao_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [ADDR_W-1:0]         push_addr,
    input  byte_t                     push_data,
    input  logic                      pop,
    input  logic                      flush,
    output logic [ADDR_W-1:0]         head_addr,
    output byte_t                     head_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    byte_t             data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/misao_fetch_buffer.sv
// Byte prefetch buffer between the misao core and a one-cycle-latency SRAM:
// zero-latency sequential fetch via FIFO hit or in-flight bypass.
module misao_fetch_buffer
    import misao_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_rd_en,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  byte_t             core_wdata,
    output byte_t             core_rdata,
    output logic              core_ready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output byte_t             sram_wdata,
    input  byte_t             sram_rdata
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fb_state_e         state, state_nxt;
    logic [ADDR_W-1:0] pf_addr, pf_addr_nxt;
    logic              epoch, epoch_nxt;

    logic              infl_valid, infl_valid_nxt;
    inflight_kind_e    infl_kind, infl_kind_nxt;
    logic [ADDR_W-1:0] infl_addr, infl_addr_nxt;
    logic              infl_epoch, infl_epoch_nxt;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic [ADDR_W-1:0] head_addr;
    byte_t             head_data;
    logic [CNT_W-1:0]  fifo_count;

    logic              pf_returning;
    logic              pf_current;
    logic              bypass;
    logic              port_busy;
    logic [CNT_W:0]    occupancy;

    misao_fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_addr (infl_addr),
        .push_data (sram_rdata),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pf_addr    <= '0;
            epoch      <= 1'b0;
            infl_valid <= 1'b0;
            infl_kind  <= DEMAND;
            infl_addr  <= '0;
            infl_epoch <= 1'b0;
        end else begin
            state      <= state_nxt;
            pf_addr    <= pf_addr_nxt;
            epoch      <= epoch_nxt;
            infl_valid <= infl_valid_nxt;
            infl_kind  <= infl_kind_nxt;
            infl_addr  <= infl_addr_nxt;
            infl_epoch <= infl_epoch_nxt;
        end
    end

    // Outputs are forced to zero while reset is held so an outstanding core
    // request cannot reach the SRAM during reset.
    always_comb begin
        state_nxt      = state;
        pf_addr_nxt    = pf_addr;
        epoch_nxt      = epoch;
        infl_valid_nxt = 1'b0;
        infl_kind_nxt  = infl_kind;
        infl_addr_nxt  = infl_addr;
        infl_epoch_nxt = infl_epoch;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        fifo_flush     = 1'b0;
        bypass         = 1'b0;
        port_busy      = 1'b0;
        core_rdata     = '0;
        core_ready     = 1'b0;
        sram_en        = 1'b0;
        sram_we        = 1'b0;
        sram_addr      = '0;
        sram_wdata     = '0;

        pf_returning = infl_valid && (infl_kind == PREFETCH);
        pf_current   = pf_returning && (infl_epoch == epoch);
        occupancy    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pf_returning};

        if (rst_n) begin
            case (state)
                MISS: begin
                    core_ready = 1'b1;
                    core_rdata = sram_rdata;
                    state_nxt  = RUN;
                end
                RUN: begin
                    if (core_wr_en) begin
                        sram_en    = 1'b1;
                        sram_we    = 1'b1;
                        sram_addr  = core_addr;
                        sram_wdata = core_wdata;
                        core_ready = 1'b1;
                        fifo_flush = 1'b1;
                        epoch_nxt  = ~epoch;
                        port_busy  = 1'b1;
                    end else if (core_rd_en) begin
                        if ((fifo_count != '0) && (head_addr == core_addr)) begin
                            core_ready = 1'b1;
                            core_rdata = head_data;
                            fifo_pop   = 1'b1;
                        end else if ((fifo_count == '0) && pf_current && (infl_addr == core_addr)) begin
                            core_ready = 1'b1;
                            core_rdata = sram_rdata;
                            bypass     = 1'b1;
                        end else begin
                            fifo_flush     = 1'b1;
                            epoch_nxt      = ~epoch;
                            sram_en        = 1'b1;
                            sram_addr      = core_addr;
                            infl_valid_nxt = 1'b1;
                            infl_kind_nxt  = DEMAND;
                            infl_addr_nxt  = core_addr;
                            infl_epoch_nxt = ~epoch;
                            pf_addr_nxt    = core_addr + ADDR_W'(1);
                            state_nxt      = MISS;
                            port_busy      = 1'b1;
                        end
                    end
                end
                default: state_nxt = RUN;
            endcase

            // The port is also free while the demand data returns, so the
            // stream restarts right behind a miss and the next fetch can bypass.
            if (!port_busy && (occupancy < (CNT_W+1)'(DEPTH))) begin
                sram_en        = 1'b1;
                sram_addr      = pf_addr;
                infl_valid_nxt = 1'b1;
                infl_kind_nxt  = PREFETCH;
                infl_addr_nxt  = pf_addr;
                infl_epoch_nxt = epoch;
                pf_addr_nxt    = pf_addr + ADDR_W'(1);
            end

            fifo_push = pf_current && !bypass && !fifo_flush;
        end
    end

endmodule

// File: tb/tb_misao_fetch_buffer.sv
// Self-checking bench for misao_fetch_buffer: transaction-level model of the
// buffer plus directed fetch, branch, write, wrap and reset scenarios.
module tb_misao_fetch_buffer;
    import misao_pkg::*;

    localparam int AW    = DEFAULT_ADDR_W;
    localparam int DEPTH = 2;
    localparam int MEM_N = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_rd_en = 1'b0;
    logic          core_wr_en = 1'b0;
    logic [AW-1:0] core_addr = '0;
    byte_t         core_wdata = '0;
    byte_t         core_rdata;
    logic          core_ready;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    byte_t         sram_wdata;
    byte_t         sram_rdata = '0;

    int checks = 0;
    int errors = 0;

    misao_fetch_buffer #(
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_rd_en (core_rd_en),
        .core_wr_en (core_wr_en),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ready (core_ready),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM environment with one-cycle read latency
    byte_t sram_mem [MEM_N];

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) sram_mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= sram_mem[sram_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: prefetched address queue, the access issued last cycle, and
    // whether the core is waiting on a demand read.
    byte_t         model_mem [MEM_N];
    logic [AW-1:0] m_q [$];
    bit            m_miss;
    bit            m_pend_valid;
    bit            m_pend_pf;
    logic [AW-1:0] m_pend_addr;
    logic [AW-1:0] m_pf;

    bit            e_ready, e_en, e_we;
    byte_t         e_rdata, e_wdata;
    logic [AW-1:0] e_addr;
    bit            m_flush, m_bypass, m_busy, m_is_miss;
    int            m_size0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_miss       = 0;
            m_pend_valid = 0;
            m_pend_pf    = 0;
            m_pend_addr  = '0;
            m_pf         = '0;
            checkOutput("rst_core_ready", core_ready, 0);
            checkOutput("rst_sram_en", sram_en, 0);
        end else begin
            e_ready = 0; e_en = 0; e_we = 0; e_rdata = '0; e_wdata = '0; e_addr = '0;
            m_flush = 0; m_bypass = 0; m_busy = 0; m_is_miss = 0;
            m_size0 = m_q.size();

            if (m_miss) begin
                e_ready = 1;
                e_rdata = model_mem[m_pend_addr];
                m_miss  = 0;
            end else if (core_wr_en) begin
                e_en = 1; e_we = 1; e_addr = core_addr; e_wdata = core_wdata;
                e_ready = 1; m_flush = 1; m_busy = 1;
                model_mem[core_addr] = core_wdata;
            end else if (core_rd_en) begin
                if (m_q.size() > 0 && m_q[0] == core_addr) begin
                    e_ready = 1;
                    e_rdata = model_mem[core_addr];
                    void'(m_q.pop_front());
                end else if (m_q.size() == 0 && m_pend_valid && m_pend_pf && m_pend_addr == core_addr) begin
                    e_ready  = 1;
                    e_rdata  = model_mem[core_addr];
                    m_bypass = 1;
                end else begin
                    e_en = 1; e_addr = core_addr;
                    m_flush = 1; m_busy = 1; m_is_miss = 1;
                end
            end

            if (m_flush) m_q.delete();
            if (m_pend_valid && m_pend_pf && !m_flush && !m_bypass) m_q.push_back(m_pend_addr);

            if (m_is_miss) begin
                m_pend_valid = 1; m_pend_pf = 0; m_pend_addr = core_addr;
                m_pf   = AW'((int'(core_addr) + 1) % MEM_N);
                m_miss = 1;
            end else if (!m_busy && (m_size0 + ((m_pend_valid && m_pend_pf) ? 1 : 0)) < DEPTH) begin
                e_en = 1; e_addr = m_pf;
                m_pend_valid = 1; m_pend_pf = 1; m_pend_addr = m_pf;
                m_pf = AW'((int'(m_pf) + 1) % MEM_N);
            end else begin
                m_pend_valid = 0;
            end

            checkOutput("core_ready", core_ready, e_ready);
            if (e_ready && core_rd_en) checkOutput("core_rdata", core_rdata, e_rdata);
            checkOutput("sram_en", sram_en, e_en);
            if (e_en) begin
                checkOutput("sram_we", sram_we, e_we);
                checkOutput("sram_addr", sram_addr, e_addr);
            end
            if (e_we) checkOutput("sram_wdata", sram_wdata, e_wdata);
        end
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] a, input byte_t d);
        @(posedge clk);
        #1;
        core_rd_en = rd;
        core_wr_en = wr;
        core_addr  = a;
        core_wdata = d;
    endtask

    task automatic readOp(input string name, input logic [AW-1:0] a, input byte_t exp_data, input int exp_wait);
        int waited = 0;
        bit done = 0;
        applyStimulus(1'b1, 1'b0, a, 8'h00);
        while (!done) begin
            @(negedge clk);
            if (core_ready) begin
                done = 1;
                checkOutput({name, "_data"}, core_rdata, exp_data);
                checkOutput({name, "_wait"}, waited, exp_wait);
            end else begin
                waited++;
                if (waited > 8) begin
                    checkOutput({name, "_ready_timeout"}, core_ready, 1);
                    done = 1;
                end
            end
        end
    endtask

    task automatic writeOp(input string name, input logic [AW-1:0] a, input byte_t d);
        applyStimulus(1'b0, 1'b1, a, d);
        @(negedge clk);
        checkOutput({name, "_ready"}, core_ready, 1);
        checkOutput({name, "_we"}, sram_we, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < MEM_N; i++) begin
            sram_mem[i]  = byte_t'(i) ^ 8'h5A;
            model_mem[i] = byte_t'(i) ^ 8'h5A;
        end
        begin
            int    addrs [13] = '{1, 2, 3, 4, 5, 6, 7, 8, 20, 21, 32767, 0, 50};
            byte_t vals  [13] = '{8'h14, 8'h03, 8'h05, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88,
                                  8'h20, 8'h44, 8'h3C, 8'hA0, 8'h6B};
            for (int i = 0; i < 13; i++) begin
                sram_mem[addrs[i]]  = vals[i];
                model_mem[addrs[i]] = vals[i];
            end
            sram_mem[100]  = 8'hC1;
            model_mem[100] = 8'hC1;
            sram_mem[40]   = 8'h11;
            model_mem[40]  = 8'h11;
        end

        #2;
        checkOutput("init_core_ready", core_ready, 0);
        checkOutput("init_core_rdata", core_rdata, 0);
        checkOutput("init_sram_en", sram_en, 0);
        checkOutput("init_sram_addr", sram_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] sequential fetch");
        readOp("seq1", 15'd1, 8'h14, 1);
        readOp("seq2", 15'd2, 8'h03, 0);
        readOp("seq3", 15'd3, 8'h05, 0);
        readOp("seq4", 15'd4, 8'h00, 0);
        idle(1);

        $display("[TB] branch flush");
        readOp("hit5", 15'd5, 8'h55, 0);
        readOp("hit6", 15'd6, 8'h66, 0);
        readOp("br8", 15'd8, 8'h88, 1);

        $display("[TB] write coherency");
        readOp("rd20", 15'd20, 8'h20, 1);
        idle(2);
        writeOp("wr21", 15'd21, 8'h99);
        readOp("coh21", 15'd21, 8'h99, 1);

        $display("[TB] address wrap");
        readOp("wraphi", 15'h7FFF, 8'h3C, 1);
        checkOutput("wrap_pf_en", sram_en, 1);
        checkOutput("wrap_pf_addr", sram_addr, 0);
        readOp("wrap0", 15'h0000, 8'hA0, 0);

        $display("[TB] reset during miss");
        applyStimulus(1'b1, 1'b0, 15'd100, 8'h00);
        @(negedge clk);
        checkOutput("rstmiss_ready", core_ready, 0);
        checkOutput("rstmiss_addr", sram_addr, 100);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstmiss_core_ready", core_ready, 0);
        checkOutput("rstmiss_core_rdata", core_rdata, 0);
        checkOutput("rstmiss_sram_en", sram_en, 0);
        checkOutput("rstmiss_sram_addr", sram_addr, 0);
        core_rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        readOp("postrst", 15'd100, 8'hC1, 1);

        $display("[TB] write then read");
        writeOp("b2bwr", 15'd40, 8'h5E);
        applyStimulus(1'b1, 1'b0, 15'd50, 8'h00);
        @(negedge clk);
        checkOutput("b2b_we_low", sram_we, 0);
        checkOutput("b2b_en", sram_en, 1);
        checkOutput("b2b_addr", sram_addr, 50);
        checkOutput("b2b_stall", core_ready, 0);
        @(negedge clk);
        checkOutput("b2b_ready", core_ready, 1);
        checkOutput("b2b_data", core_rdata, 8'h6B);
        readOp("rd40", 15'd40, 8'h5E, 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
